rx_cmd_ctrl: RTL and testbench
==============================

RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, width of RX byte, RF data and TX byte.
REQ-002 SHALL have parameter ADDR_WD, default 4, register-file address width.
REQ-003 SHALL have parameter FUN_WD, default 4, ALU function-code width.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WD  received byte from UART RX.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid.
REQ-008 SHALL have port RF_RdData  input  DATA_WD  register-file read data.
REQ-009 SHALL have port RF_RdData_VLD  input  1  read data valid strobe.
REQ-010 SHALL have port ALU_OUT  input  2*DATA_WD  ALU result.
REQ-011 SHALL have port ALU_OUT_VLD  input  1  ALU result valid strobe.
REQ-012 SHALL have port FIFO_FULL  input  1  TX FIFO cannot accept a write.
REQ-013 SHALL have ports RF_Address (ADDR_WD), RF_WrEn, RF_RdEn, RF_WrData (DATA_WD)  outputs  register-file access.
REQ-014 SHALL have ports ALU_FUN (FUN_WD), ALU_EN, CLK_GATE_EN  outputs  ALU command and ALU clock-gate enable.
REQ-015 SHALL have ports TX_P_DATA (DATA_WD), TX_D_VLD  outputs  TX FIFO write data and one-cycle write strobe.

Function
REQ-016 SHALL decode the first byte of each frame: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte SHALL be discarded with state remaining IDLE.
REQ-017 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_CMD, ALU_WAIT, TX_LO, TX_HI, RD_TX.
REQ-018 0xAA: next byte latched as address (low ADDR_WD bits); following byte SHALL produce exactly one cycle of RF_WrEn=1 with that address/data in the cycle after RX_D_VLD; return to IDLE.
REQ-019 0xBB: next byte SHALL produce one-cycle RF_RdEn with address; state RD_WAIT until RF_RdData_VLD, data latched, then RD_TX pushes it to TX.
REQ-020 0xCC: operand A SHALL be written to RF address 0, operand B to address 1 (one RF_WrEn cycle each), then the function byte moves to ALU_CMD.
REQ-021 0xDD: next byte SHALL go directly to ALU_CMD.
REQ-022 ALU_CMD SHALL assert ALU_EN for one cycle with ALU_FUN = low FUN_WD bits of function byte; ALU_WAIT holds until ALU_OUT_VLD, latching the 16-bit result.
REQ-023 CLK_GATE_EN SHALL be 1 in OP_B(after write), ALU_CMD and ALU_WAIT, and in the cycle before ALU_EN; 0 elsewhere.
REQ-024 TX_LO then TX_HI SHALL push result low byte then high byte; each push is a one-cycle TX_D_VLD only when FIFO_FULL=0; while FIFO_FULL=1 the state and TX_P_DATA SHALL hold.
REQ-025 RX_D_VLD arriving in RD_WAIT, ALU_WAIT, ALU_CMD, RD_TX, TX_LO, TX_HI SHALL be dropped (no buffering).
REQ-026 RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD SHALL be mutually exclusive and never asserted two cycles in a row for the same frame step.
REQ-027 Latency: RX_D_VLD of final operand byte to RF_WrEn/RF_RdEn/ALU_EN SHALL be exactly 1 cycle; valid strobe to first TX_D_VLD (FIFO not full) SHALL be 1 cycle.

Reset
REQ-028 RST=0 SHALL asynchronously force IDLE and all outputs, latched address, data and result registers to 0.
REQ-029 RST asserted mid-frame SHALL abort the frame; after release the next byte is decoded as a command.

Structure
REQ-030 Command codes (0xAA/0xBB/0xCC/0xDD) and state encoding SHALL live in a shared package/constants file used by controller and testbench.
REQ-031 Single module, no sub-modules; outputs registered.

Verification
REQ-032 Bytes AA,05,3C -> one cycle RF_WrEn=1, RF_Address=5, RF_WrData=0x3C; back to IDLE.
REQ-033 Bytes BB,07, RF_RdData=0x5A with VLD 2 cycles later -> RF_RdEn pulse addr 7, then TX_D_VLD with TX_P_DATA=0x5A.
REQ-034 Bytes CC,10,20,00, ALU_OUT=0x0030 -> writes addr0=0x10, addr1=0x20, ALU_EN with ALU_FUN=0, TX bytes 0x30 then 0x00.
REQ-035 Bytes DD,02 with FIFO_FULL=1 for 5 cycles during TX_LO -> no TX_D_VLD while full, then both bytes in order, none lost or duplicated.
REQ-036 Byte 0x11 then AA,01,FF -> 0x11 ignored, write to addr 1 = 0xFF.
REQ-037 RST low after AA,03 -> outputs 0; subsequent BB,03 executes as read.

Source files
------------

// File: rtl/rx_cmd_ctrl_pkg.sv
// Shared command codes and controller state encoding for rx_cmd_ctrl.
package rx_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR     = 8'hAA;
  localparam logic [7:0] CMD_RF_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP    = 8'hCC;
  localparam logic [7:0] CMD_ALU_NO_OP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    ALU_CMD  = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10,
    RD_TX    = 4'd11
  } state_e;

endpackage

// File: rtl/rx_cmd_ctrl.sv
// UART command-frame controller: decodes RX bytes into register-file
// writes/reads and ALU operations, and pushes results to the TX FIFO.
// All outputs are registered; strobes appear the cycle after the
// triggering input strobe.
module rx_cmd_ctrl
  import rx_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4,
  parameter int FUN_WD  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_WD-1:0]   RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [DATA_WD-1:0]   RF_RdData,
  input  logic                 RF_RdData_VLD,
  input  logic [2*DATA_WD-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  input  logic                 FIFO_FULL,
  output logic [ADDR_WD-1:0]   RF_Address,
  output logic                 RF_WrEn,
  output logic                 RF_RdEn,
  output logic [DATA_WD-1:0]   RF_WrData,
  output logic [FUN_WD-1:0]    ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_GATE_EN,
  output logic [DATA_WD-1:0]   TX_P_DATA,
  output logic                 TX_D_VLD
);

  state_e                 state_q, state_d;
  logic                   opb_done_q, opb_done_d;
  logic [ADDR_WD-1:0]     addr_q, addr_d;
  logic [DATA_WD-1:0]     wdata_q, wdata_d;
  logic [FUN_WD-1:0]      fun_q, fun_d;
  logic [2*DATA_WD-1:0]   res_q, res_d;
  logic [DATA_WD-1:0]     rdat_q, rdat_d;
  logic [DATA_WD-1:0]     tx_data_q, tx_data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_en_q, rd_en_d;
  logic                   alu_en_q, alu_en_d;
  logic                   tx_vld_q, tx_vld_d;
  logic                   gate_q, gate_d;

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      opb_done_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fun_q      <= '0;
      res_q      <= '0;
      rdat_q     <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      tx_vld_q   <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opb_done_q <= opb_done_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fun_q      <= fun_d;
      res_q      <= res_d;
      rdat_q     <= rdat_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      tx_vld_q   <= tx_vld_d;
      gate_q     <= gate_d;
    end
  end

  // Next-state and next-output decode. The wait states push the first TX
  // byte directly when the FIFO has room so the result reaches TX one cycle
  // after its valid strobe; TX_LO / RD_TX are only entered when it is full.
  always_comb begin
    state_d    = state_q;
    opb_done_d = opb_done_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fun_d      = fun_q;
    res_d      = res_q;
    rdat_d     = rdat_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    tx_vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WD'(CMD_RF_WR)) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == DATA_WD'(CMD_RF_RD)) begin
            state_d = RD_ADDR;
          end else if (RX_P_DATA == DATA_WD'(CMD_ALU_OP)) begin
            state_d = OP_A;
          end else if (RX_P_DATA == DATA_WD'(CMD_ALU_NO_OP)) begin
            // No operands: enter OP_B already past its operand write.
            state_d    = OP_B;
            opb_done_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WD-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wr_en_d = 1'b1;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WD-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RdData_VLD) begin
          rdat_d = RF_RdData;
          if (!FIFO_FULL) begin
            tx_data_d = RF_RdData;
            tx_vld_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = RD_TX;
          end
        end
      end
      RD_TX: begin
        if (!FIFO_FULL) begin
          tx_data_d = rdat_q;
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          addr_d     = '0;
          wdata_d    = RX_P_DATA;
          wr_en_d    = 1'b1;
          opb_done_d = 1'b0;
          state_d    = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          if (!opb_done_q) begin
            addr_d     = ADDR_WD'(1);
            wdata_d    = RX_P_DATA;
            wr_en_d    = 1'b1;
            opb_done_d = 1'b1;
          end else begin
            fun_d    = RX_P_DATA[FUN_WD-1:0];
            alu_en_d = 1'b1;
            state_d  = ALU_CMD;
          end
        end
      end
      ALU_CMD: state_d = ALU_WAIT;
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_d = ALU_OUT;
          if (!FIFO_FULL) begin
            tx_data_d = ALU_OUT[DATA_WD-1:0];
            tx_vld_d  = 1'b1;
            state_d   = TX_HI;
          end else begin
            state_d = TX_LO;
          end
        end
      end
      TX_LO: begin
        if (!FIFO_FULL) begin
          tx_data_d = res_q[DATA_WD-1:0];
          tx_vld_d  = 1'b1;
          state_d   = TX_HI;
        end
      end
      TX_HI: begin
        if (!FIFO_FULL) begin
          tx_data_d = res_q[2*DATA_WD-1:DATA_WD];
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gate_d = (state_d == OP_B && opb_done_d) || (state_d == ALU_CMD) ||
             (state_d == ALU_WAIT);
  end

  assign RF_Address  = addr_q;
  assign RF_WrEn     = wr_en_q;
  assign RF_RdEn     = rd_en_q;
  assign RF_WrData   = wdata_q;
  assign ALU_FUN     = fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed self-checking bench for rx_cmd_ctrl. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_rx_cmd_ctrl;
  import rx_cmd_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic [3:0]  RF_Address;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [7:0]  RF_WrData;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rx_cmd_ctrl #(.DATA_WD(8), .ADDR_WD(4), .FUN_WD(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: present a byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0;
    RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_outs", {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN,
                     CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    // RF write AA,05,3C
    send_byte(8'hAA);
    send_byte(8'h05);
    chk("wr_state_data", dut.state_q, WR_DATA);
    send_byte(8'h3C);
    chk("wr_en", RF_WrEn, 1'b1);
    chk("wr_addr", RF_Address, 4'h5);
    chk("wr_data", RF_WrData, 8'h3C);
    chk("wr_rden", RF_RdEn, 1'b0);
    chk("wr_idle", dut.state_q, IDLE);
    @(negedge CLK);
    chk("wr_en_off", RF_WrEn, 1'b0);

    // RF read BB,07, data 5A two cycles after RdEn; AA in RD_WAIT dropped
    send_byte(8'hBB);
    send_byte(8'h07);
    chk("rd_en", RF_RdEn, 1'b1);
    chk("rd_addr", RF_Address, 4'h7);
    send_byte(8'hAA);
    chk("rd_en_off", RF_RdEn, 1'b0);
    chk("rd_wait", dut.state_q, RD_WAIT);
    RF_RdData = 8'h5A; RF_RdData_VLD = 1'b1;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    chk("rd_tx_vld", TX_D_VLD, 1'b1);
    chk("rd_tx_data", TX_P_DATA, 8'h5A);
    @(negedge CLK);
    chk("rd_tx_off", TX_D_VLD, 1'b0);
    chk("rd_drop_idle", dut.state_q, IDLE);

    // ALU with operands CC,10,20,00 -> 0x0030
    send_byte(8'hCC);
    send_byte(8'h10);
    chk("opa_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h0, 8'h10});
    chk("opa_gate", CLK_GATE_EN, 1'b0);
    send_byte(8'h20);
    chk("opb_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h1, 8'h20});
    chk("opb_gate", CLK_GATE_EN, 1'b1);
    send_byte(8'h00);
    chk("alu_en", {ALU_EN, ALU_FUN, RF_WrEn}, {1'b1, 4'h0, 1'b0});
    chk("alu_cmd_gate", CLK_GATE_EN, 1'b1);
    @(negedge CLK);
    chk("alu_en_off", ALU_EN, 1'b0);
    chk("alu_wait", dut.state_q, ALU_WAIT);
    chk("alu_wait_gate", CLK_GATE_EN, 1'b1);
    ALU_OUT = 16'h0030; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    chk("cc_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h30});
    chk("cc_gate_off", CLK_GATE_EN, 1'b0);
    @(negedge CLK);
    chk("cc_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
    @(negedge CLK);
    chk("cc_tx_off", TX_D_VLD, 1'b0);
    chk("cc_idle", dut.state_q, IDLE);

    // ALU without operands DD,02, FIFO full 5 cycles in TX_LO
    send_byte(8'hDD);
    chk("dd_opb_gate", {dut.state_q == OP_B, CLK_GATE_EN}, 2'b11);
    send_byte(8'h02);
    chk("dd_alu_en", {ALU_EN, ALU_FUN}, {1'b1, 4'h2});
    @(negedge CLK);
    FIFO_FULL = 1'b1; ALU_OUT = 16'hA55A; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("full_no_vld", TX_D_VLD, 1'b0);
      chk("full_hold", {dut.state_q == TX_LO, TX_P_DATA}, {1'b1, 8'h00});
      if (i == 2) send_byte(8'hBB);
      else @(negedge CLK);
    end
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    chk("dd_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h5A});
    @(negedge CLK);
    chk("dd_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hA5});
    @(negedge CLK);
    chk("dd_tx_off", TX_D_VLD, 1'b0);
    chk("dd_idle", dut.state_q, IDLE);

    // Unknown byte 11 ignored, then AA,01,FF
    send_byte(8'h11);
    chk("junk_idle", dut.state_q, IDLE);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    chk("junk_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h1, 8'hFF});
    @(negedge CLK);

    // Reset mid-frame after AA,03, then BB,03 as a read
    send_byte(8'hAA);
    send_byte(8'h03);
    chk("mid_addr", RF_Address, 4'h3);
    #2 RST = 1'b0;
    #1;
    chk("arst_state", dut.state_q, IDLE);
    chk("arst_outs", {RF_Address, RF_WrData, ALU_FUN, TX_P_DATA, CLK_GATE_EN},
        32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_byte(8'hBB);
    send_byte(8'h03);
    chk("post_rd", {RF_RdEn, RF_WrEn, RF_Address}, {1'b1, 1'b0, 4'h3});
    RF_RdData = 8'h77; RF_RdData_VLD = 1'b1;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    chk("post_tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h77});
    @(negedge CLK);
    chk("post_idle", dut.state_q, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
